// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 32-bit MIPS datapath: write-back bypass,
// load-use bubble insertion, downstream stall/flush handling.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic [15:0]       bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } act_t;

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_imm;
  logic [ADDR_W-1:0] r_rs;
  logic [ADDR_W-1:0] r_rt;
  logic [ADDR_W-1:0] r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [15:0]       r_bcnt;

  logic w_load_use;
  logic w_wb_hit_rs;
  logic w_wb_hit_rt;
  act_t w_act;

  // Register file writes on the same edge we sample, so its read is stale.
  function automatic logic [DATA_W-1:0] byp(input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] rf);
    if (wb_we && (addr != '0) && (addr == wb_waddr))
      return wb_wdata;
    return rf;
  endfunction

  assign w_load_use = r_valid & r_ctrl[0] & id_valid & (r_rd != '0) &
                      ((r_rd == id_rs) | (r_rd == id_rt));

  assign w_wb_hit_rs = wb_we & (wb_waddr != '0) & (wb_waddr == r_rs);
  assign w_wb_hit_rt = wb_we & (wb_waddr != '0) & (wb_waddr == r_rt);

  always_comb begin
    w_act = ACT_CAPTURE;
    if (flush)
      w_act = ACT_FLUSH;
    else if (ex_stall)
      w_act = ACT_HOLD;
    else if (w_load_use)
      w_act = ACT_BUBBLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_ctrl  <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_bcnt  <= '0;
    end else begin
      case (w_act)
        ACT_FLUSH: begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
        end
        ACT_HOLD: begin
          // Held operands still track write-back so they do not go stale.
          if (w_wb_hit_rs) r_opa <= wb_wdata;
          if (w_wb_hit_rt) r_opb <= wb_wdata;
        end
        ACT_BUBBLE: begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          if (r_bcnt != 16'hFFFF) r_bcnt <= r_bcnt + 16'd1;
        end
        default: begin
          r_valid <= id_valid;
          r_ctrl  <= id_valid ? id_ctrl : '0;
          r_pc    <= id_pc;
          r_imm   <= id_imm;
          r_rs    <= id_rs;
          r_rt    <= id_rt;
          r_rd    <= id_rd;
          r_opa   <= byp(id_rs, rf_rdata1);
          r_opb   <= byp(id_rt, rf_rdata2);
        end
      endcase
    end
  end

  assign id_stall   = w_load_use | ex_stall;
  assign ex_valid   = r_valid;
  assign ex_pc      = r_pc;
  assign ex_imm     = r_imm;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_rd      = r_rd;
  assign ex_ctrl    = r_ctrl;
  assign ex_opa     = r_opa;
  assign ex_opb     = r_opb;
  assign bubble_cnt = r_bcnt;

endmodule
